// File: rtl/player_action_ctrl.sv
// player_action_ctrl: debounces the four player buttons on frame ticks and runs
// the attack sequencer (startup / active / recovery). Movement controls are
// suppressed while an attack is in progress. All outputs are registered and
// change only on clock edges where SCEN is high.
module player_action_ctrl #(
  parameter int DEB_FRAMES     = 2,
  parameter int STARTUP_FRAMES = 3,
  parameter int ACTIVE_FRAMES  = 2,
  parameter int RECOVER_FRAMES = 6,
  parameter int CNT_W          = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SCEN,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_up,
  input  logic       btn_attack,
  input  logic       jump_active,
  output logic       move_left,
  output logic       move_right,
  output logic       jump,
  output logic       move_enable,
  output logic       attack_active,
  output logic [1:0] attack_phase,
  output logic       hit_window
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    STARTUP  = 2'd1,
    ACTIVE   = 2'd2,
    RECOVERY = 2'd3
  } phase_t;

  localparam logic [3:0]       DEB_LAST     = 4'(DEB_FRAMES - 1);
  localparam logic [CNT_W-1:0] STARTUP_LAST = CNT_W'(STARTUP_FRAMES - 1);
  localparam logic [CNT_W-1:0] ACTIVE_LAST  = CNT_W'(ACTIVE_FRAMES - 1);
  localparam logic [CNT_W-1:0] RECOVER_LAST = CNT_W'(RECOVER_FRAMES - 1);

  // Button bit order: 0 left, 1 right, 2 up, 3 attack
  logic [3:0] raw;
  logic [3:0] deb_reg;
  logic [3:0] deb_next;
  logic [3:0] rise;

  assign raw = {btn_attack, btn_up, btn_right, btn_left};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_deb
      logic [3:0] deb_cnt_reg;

      // The debounced level flips only after enough consecutive differing samples
      assign deb_next[gi] = (SCEN && (raw[gi] != deb_reg[gi]) && (deb_cnt_reg == DEB_LAST))
                            ? raw[gi] : deb_reg[gi];

      // Per-button agreement counter: cleared whenever raw matches the accepted level
      always_ff @(posedge clk) begin
        if (reset) begin
          deb_cnt_reg <= '0;
        end else if (SCEN) begin
          if (raw[gi] == deb_reg[gi] || deb_cnt_reg == DEB_LAST) begin
            deb_cnt_reg <= '0;
          end else begin
            deb_cnt_reg <= deb_cnt_reg + 4'd1;
          end
        end
      end
    end
  endgenerate

  // Accepted button levels; deb_next already carries the SCEN gating
  always_ff @(posedge clk) begin
    if (reset) begin
      deb_reg <= '0;
    end else begin
      deb_reg <= deb_next;
    end
  end

  // Non-zero only on a SCEN edge where a debounced level goes 0->1
  assign rise = deb_next & ~deb_reg;

  logic atk_edge;
  logic up_edge;
  assign atk_edge = rise[3];
  assign up_edge  = rise[2];

  phase_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  // Phase and in-phase frame counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Attack sequencing; edges outside IDLE or while airborne are simply dropped
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (SCEN) begin
      case (state_reg)
        IDLE: begin
          if (atk_edge && !jump_active) begin
            state_next = STARTUP;
            cnt_next   = '0;
          end
        end
        STARTUP: begin
          if (cnt_reg == STARTUP_LAST) begin
            state_next = ACTIVE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        ACTIVE: begin
          if (cnt_reg == ACTIVE_LAST) begin
            state_next = RECOVERY;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
        default: begin
          if (cnt_reg == RECOVER_LAST) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      endcase
    end
  end

  logic       move_left_next, move_right_next, jump_next;
  logic       move_enable_next, attack_active_next, hit_window_next;

  // Output values for the coming frame, aligned with the next phase
  always_comb begin
    move_enable_next   = (state_next == IDLE);
    attack_active_next = (state_next != IDLE);
    hit_window_next    = (state_next == ACTIVE);
    move_left_next     = deb_next[0] & ~deb_next[1] & move_enable_next;
    move_right_next    = deb_next[1] & ~deb_next[0] & move_enable_next;
    jump_next          = (state_reg == IDLE) && up_edge && !jump_active && !atk_edge;
  end

  // Registered outputs, held for the whole frame
  always_ff @(posedge clk) begin
    if (reset) begin
      move_left     <= 1'b0;
      move_right    <= 1'b0;
      jump          <= 1'b0;
      move_enable   <= 1'b1;
      attack_active <= 1'b0;
      attack_phase  <= 2'd0;
      hit_window    <= 1'b0;
    end else if (SCEN) begin
      move_left     <= move_left_next;
      move_right    <= move_right_next;
      jump          <= jump_next;
      move_enable   <= move_enable_next;
      attack_active <= attack_active_next;
      attack_phase  <= state_next;
      hit_window    <= hit_window_next;
    end
  end

endmodule

// File: tb/tb_player_action_ctrl.sv
// Directed bench for player_action_ctrl with default parameters
// (DEB_FRAMES=2, STARTUP=3, ACTIVE=2, RECOVER=6).
module tb_player_action_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       SCEN = 1'b0;
  logic       btn_left = 1'b0, btn_right = 1'b0, btn_up = 1'b0, btn_attack = 1'b0;
  logic       jump_active = 1'b0;
  logic       move_left, move_right, jump, move_enable, attack_active, hit_window;
  logic [1:0] attack_phase;

  int checks = 0;
  int failures = 0;

  player_action_ctrl dut (
    .clk(clk), .reset(reset), .SCEN(SCEN),
    .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up),
    .btn_attack(btn_attack), .jump_active(jump_active),
    .move_left(move_left), .move_right(move_right), .jump(jump),
    .move_enable(move_enable), .attack_active(attack_active),
    .attack_phase(attack_phase), .hit_window(hit_window)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  // One frame: SCEN high for exactly one posedge, then a quiet cycle.
  // Returns at a negedge, so outputs are sampled away from the active edge.
  task automatic frame();
    @(negedge clk) SCEN = 1'b1;
    @(negedge clk) SCEN = 1'b0;
    @(negedge clk);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) frame();
  endtask

  initial begin
    int exp_ph4[12];
    int exp_ph5[12];
    int n_jump;
    int n_dis;
    int n_hit;

    exp_ph4 = '{1, 1, 1, 2, 2, 3, 3, 3, 3, 3, 3, 0};
    exp_ph5 = '{1, 1, 2, 2, 3, 3, 3, 3, 3, 3, 0, 0};

    // Reset state
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_val("rst_phase", attack_phase, 0);
    check_val("rst_move_enable", move_enable, 1);
    check_val("rst_move_lr", {move_left, move_right}, 0);
    check_val("rst_jump", jump, 0);
    check_val("rst_hit", hit_window, 0);
    check_val("rst_attack_active", attack_active, 0);

    // 1: debounce latency on press and release
    btn_right = 1'b1;
    frame();
    check_val("t1_right_f1", move_right, 0);
    frame();
    check_val("t1_right_f2", move_right, 1);
    btn_right = 1'b0;
    frame();
    check_val("t1_rel_f1", move_right, 1);
    frame();
    check_val("t1_rel_f2", move_right, 0);

    // 2: single-sample glitch is rejected
    btn_left = 1'b1;
    frame();
    btn_left = 1'b0;
    frame();
    check_val("t2_glitch_a", move_left, 0);
    frame();
    check_val("t2_glitch_b", move_left, 0);

    // 3: jump pulse, no auto-repeat, suppressed while airborne
    btn_up = 1'b1;
    frame();
    check_val("t3_jump_f1", jump, 0);
    frame();
    check_val("t3_jump_f2", jump, 1);
    frame();
    check_val("t3_jump_f3", jump, 0);
    n_jump = 0;
    for (int i = 0; i < 8; i++) begin
      frame();
      if (jump) n_jump++;
    end
    check_val("t3_no_repeat", n_jump, 0);
    btn_up = 1'b0;
    frames(2);
    jump_active = 1'b1;
    btn_up = 1'b1;
    n_jump = 0;
    for (int i = 0; i < 3; i++) begin
      frame();
      if (jump) n_jump++;
    end
    check_val("t3_airborne_jump", n_jump, 0);
    btn_up = 1'b0;
    frames(2);
    jump_active = 1'b0;

    // 4: full attack with btn_right held
    btn_right = 1'b1;
    frames(2);
    check_val("t4_right_pre", move_right, 1);
    btn_attack = 1'b1;
    frame();
    check_val("t4_phase_f1", attack_phase, 0);
    n_dis = 0;
    n_hit = 0;
    for (int i = 0; i < 12; i++) begin
      frame();
      check_val($sformatf("t4_phase[%0d]", i), attack_phase, exp_ph4[i]);
      check_val($sformatf("t4_right[%0d]", i), move_right, (exp_ph4[i] == 0) ? 1 : 0);
      check_val($sformatf("t4_active[%0d]", i), attack_active, (exp_ph4[i] != 0) ? 1 : 0);
      if (!move_enable) n_dis++;
      if (hit_window) n_hit++;
    end
    check_val("t4_move_disabled_frames", n_dis, 11);
    check_val("t4_hit_frames", n_hit, 2);
    frame();
    check_val("t4_no_autorepeat", attack_phase, 0);
    btn_attack = 1'b0;
    btn_right = 1'b0;
    frames(2);

    // 5: simultaneous attack+up edges, then attack re-press in RECOVERY
    btn_attack = 1'b1;
    btn_up = 1'b1;
    frame();
    frame();
    check_val("t5_phase_start", attack_phase, 1);
    check_val("t5_jump", jump, 0);
    btn_attack = 1'b0;
    btn_up = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i == 5) btn_attack = 1'b1;
      frame();
      check_val($sformatf("t5_phase[%0d]", i), attack_phase, exp_ph5[i]);
    end
    btn_attack = 1'b0;
    frames(2);

    // 6: reset mid-ACTIVE aborts the attack
    btn_attack = 1'b1;
    btn_left = 1'b1;
    frames(5);
    check_val("t6_pre_phase", attack_phase, 2);
    check_val("t6_pre_hit", hit_window, 1);
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    check_val("t6_phase", attack_phase, 0);
    check_val("t6_hit", hit_window, 0);
    check_val("t6_move_enable", move_enable, 1);
    check_val("t6_move", {move_left, move_right, jump}, 0);
    check_val("t6_attack_active", attack_active, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
